// File: rtl/sfi_unit.sv
// sfi_unit -- software-fault-isolation address checker.
//
// Every effective address presented on ri is checked against a sandbox tag
// in its upper 32 bits. Legal addresses pass through unchanged; illegal ones
// are neutralised and reported. The result is registered (1-cycle latency,
// one access per cycle, no back-pressure).
//
// Parameters:
//   SANDBOX_TAG  required value of address bits [63:32]
//   TAG_MASK     tag bits that take part in the compare (1 = compared)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   ri_valid      ri carries an effective address this cycle
//   ri[63:0]      effective address in
//   fault_clr     clears fault_sticky (a simultaneous violation wins)
//   ro[63:0]      checked address out (held while ro_valid is low)
//   ro_valid      ro is valid this cycle
//   fault         per-access violation flag, aligned with ro
//   fault_sticky  set by any violation, held until fault_clr
//   fault_cnt     saturating violation count, unaffected by fault_clr
//
// Build option:
//   SFI_SANDBOX_FORCE_EN  when defined, an illegal address is forced into the
//                         sandbox ({SANDBOX_TAG, ri[31:0]}) instead of zeroed.

module sfi_unit #(
  parameter logic [31:0] SANDBOX_TAG = 32'hA219_9872,
  parameter logic [31:0] TAG_MASK    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ri_valid,
  input  logic [63:0] ri,
  input  logic        fault_clr,
  output logic [63:0] ro,
  output logic        ro_valid,
  output logic        fault,
  output logic        fault_sticky,
  output logic [15:0] fault_cnt
);

  logic        legal;
  logic        violation;
  logic [63:0] bad_addr;

  // Only the tag half is examined; the offset half never affects legality.
  assign legal     = (ri[63:32] & TAG_MASK) == (SANDBOX_TAG & TAG_MASK);
  assign violation = ri_valid && !legal;

`ifdef SFI_SANDBOX_FORCE_EN
  assign bad_addr = {SANDBOX_TAG, ri[31:0]};
`else
  assign bad_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ro           <= '0;
      ro_valid     <= 1'b0;
      fault        <= 1'b0;
      fault_sticky <= 1'b0;
      fault_cnt    <= '0;
    end else begin
      ro_valid <= ri_valid;
      fault    <= violation;

      // ro holds its last value across idle cycles.
      if (ri_valid) begin
        ro <= legal ? ri : bad_addr;
      end

      // A new violation outranks a clear arriving in the same cycle.
      if (violation) begin
        fault_sticky <= 1'b1;
      end else if (fault_clr) begin
        fault_sticky <= 1'b0;
      end

      if (violation && (fault_cnt != '1)) begin
        fault_cnt <= fault_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sfi_unit.sv
// tb_sfi_unit -- self-checking bench for sfi_unit.
// Table-driven vectors feed a scoreboard queue of expected results that is
// popped one cycle after each drive; a hand-written sequence covers counter
// saturation. Honours SFI_SANDBOX_FORCE_EN for the expected illegal output.

module tb_sfi_unit;

  localparam logic [31:0] TAG  = 32'hA219_9872;
  localparam logic [63:0] LEG  = 64'hA219_9872_0000_0000;
  localparam logic [63:0] LEG2 = 64'hA219_9872_FFFF_FFFF;
  localparam logic [63:0] BAD  = 64'hBAD0_ADD0_1234_5678;
  localparam logic [63:0] BAD1 = 64'hA219_9873_0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        ri_valid;
  logic [63:0] ri;
  logic        fault_clr;
  logic [63:0] ro;
  logic        ro_valid;
  logic        fault;
  logic        fault_sticky;
  logic [15:0] fault_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sfi_unit #(
    .SANDBOX_TAG(32'hA219_9872),
    .TAG_MASK   (32'hFFFF_FFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ri_valid    (ri_valid),
    .ri          (ri),
    .fault_clr   (fault_clr),
    .ro          (ro),
    .ro_valid    (ro_valid),
    .fault       (fault),
    .fault_sticky(fault_sticky),
    .fault_cnt   (fault_cnt)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic        clr;
    logic [63:0] ri;
    logic [63:0] e_ro;
    logic        e_v;
    logic        e_f;
    logic        e_s;
    logic [15:0] e_c;
  } vec_t;

  typedef struct {
    string       tag;
    logic [63:0] ro;
    logic        v;
    logic        f;
    logic        s;
    logic [15:0] c;
  } exp_t;

  exp_t sb[$];

  function automatic logic [63:0] bad_ro(input logic [63:0] a);
`ifdef SFI_SANDBOX_FORCE_EN
    return {TAG, a[31:0]};
`else
    return 64'h0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its expectation.
  task automatic drive(input logic r, input logic v, input logic c, input logic [63:0] a,
                       input exp_t e);
    @(negedge clk);
    rst = r; ri_valid = v; fault_clr = c; ri = a;
    sb.push_back(e);
  endtask

  // Compare the DUT against the oldest queued expectation, 1 unit after the edge.
  task automatic collect(input bit full);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".fault_cnt"}, {48'h0, fault_cnt}, {48'h0, e.c});
      if (full) begin
        chk({e.tag, ".ro"},           ro,                   e.ro);
        chk({e.tag, ".ro_valid"},     {63'h0, ro_valid},     {63'h0, e.v});
        chk({e.tag, ".fault"},        {63'h0, fault},        {63'h0, e.f});
        chk({e.tag, ".fault_sticky"}, {63'h0, fault_sticky}, {63'h0, e.s});
      end
    end
  endtask

  vec_t vecs[12];

  initial begin
    exp_t e;
    int   cnt;

    rst = 1'b1; ri_valid = 1'b0; fault_clr = 1'b0; ri = '0;

    //           rst   v     clr   ri    e_ro          e_v   e_f   e_s   e_c
    vecs[0]  = '{1'b1, 1'b1, 1'b0, LEG,  64'h0,        1'b0, 1'b0, 1'b0, 16'd0}; // reset, access discarded
    vecs[1]  = '{1'b1, 1'b1, 1'b0, LEG,  64'h0,        1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, LEG,  LEG,          1'b1, 1'b0, 1'b0, 16'd0}; // first cycle after reset
    vecs[3]  = '{1'b0, 1'b1, 1'b0, BAD,  bad_ro(BAD),  1'b1, 1'b1, 1'b1, 16'd1}; // back-to-back illegal
    vecs[4]  = '{1'b0, 1'b1, 1'b0, LEG,  LEG,          1'b1, 1'b0, 1'b1, 16'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, BAD,  LEG,          1'b0, 1'b0, 1'b1, 16'd1}; // idle: ro held
    vecs[6]  = '{1'b0, 1'b1, 1'b1, BAD,  bad_ro(BAD),  1'b1, 1'b1, 1'b1, 16'd2}; // clear collides
    vecs[7]  = '{1'b0, 1'b0, 1'b1, LEG,  bad_ro(BAD),  1'b0, 1'b0, 1'b0, 16'd2}; // clear alone
    vecs[8]  = '{1'b0, 1'b1, 1'b0, LEG2, LEG2,         1'b1, 1'b0, 1'b0, 16'd2}; // offset ignored
    vecs[9]  = '{1'b0, 1'b1, 1'b0, BAD1, bad_ro(BAD1), 1'b1, 1'b1, 1'b1, 16'd3}; // one tag bit off
    vecs[10] = '{1'b1, 1'b1, 1'b0, BAD,  64'h0,        1'b0, 1'b0, 1'b0, 16'd0}; // reset beats access
    vecs[11] = '{1'b0, 1'b0, 1'b1, BAD,  64'h0,        1'b0, 1'b0, 1'b0, 16'd0};

    for (int i = 0; i < 12; i++) begin
      e = '{$sformatf("vec%0d", i), vecs[i].e_ro, vecs[i].e_v, vecs[i].e_f,
            vecs[i].e_s, vecs[i].e_c};
      drive(vecs[i].rst, vecs[i].v, vecs[i].clr, vecs[i].ri, e);
      collect(1'b1);
    end

    // Saturation: 65,536 illegal accesses, then one more.
    cnt = 0;
    for (int i = 0; i < 65537; i++) begin
      if (cnt < 16'hFFFF) cnt++;
      e = '{$sformatf("sat%0d", i), bad_ro(BAD), 1'b1, 1'b1, 1'b1, cnt[15:0]};
      drive(1'b0, 1'b1, 1'b0, BAD, e);
      collect(i >= 65534);
    end

    // Clearing the sticky flag leaves the saturated count alone.
    e = '{"sat_clr", bad_ro(BAD), 1'b0, 1'b0, 1'b0, 16'hFFFF};
    drive(1'b0, 1'b0, 1'b1, LEG, e);
    collect(1'b1);

    // A legal access after saturation does not move the count.
    e = '{"sat_legal", LEG, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    drive(1'b0, 1'b1, 1'b0, LEG, e);
    collect(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
